// File: rtl/onehot_serial_encoder.sv
// Serial multi-hot to binary encoder: accepts a request vector and streams the
// index of every set bit, lowest first, over a valid/ready output.
module onehot_serial_encoder #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [N-1:0] req_vec,
  input  logic         flush,
  output logic         idx_valid,
  input  logic         idx_ready,
  output logic [W-1:0] idx,
  output logic         idx_last,
  output logic         zero_seen,
  output logic [W:0]   bit_count
);

  // state | meaning
  // IDLE  | ready for a new vector, no index beat pending
  // DRAIN | emitting indices of the bits still set in pending_q
  typedef enum logic {IDLE, DRAIN} state_t;

  state_t       state_q, state_d;
  logic [N-1:0] pending_q, pending_d;
  logic [W:0]   bit_count_q, bit_count_d;
  logic         zero_seen_q, zero_seen_d;

  logic [W-1:0] low_idx;
  logic [W:0]   req_pop;
  logic         single_bit;

  // Priority scan from the top so the lowest set bit wins.
  always_comb begin
    low_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pending_q[i]) low_idx = W'(i);
    end
  end

  always_comb begin
    req_pop = '0;
    for (int i = 0; i < N; i++) begin
      req_pop = req_pop + (W+1)'(req_vec[i]);
    end
  end

  assign single_bit = (pending_q != '0) && ((pending_q & (pending_q - N'(1))) == '0);

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    bit_count_d = bit_count_q;
    zero_seen_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && !flush) begin
          if (req_vec != '0) begin
            pending_d   = req_vec;
            bit_count_d = req_pop;
            state_d     = DRAIN;
          end else begin
            bit_count_d = '0;
            zero_seen_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (flush) begin
          pending_d = '0;
          state_d   = IDLE;
        end else if (idx_ready) begin
          pending_d = pending_q & (pending_q - N'(1));
          if (single_bit) state_d = IDLE;
        end
      end
      default: begin
        pending_d = '0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      bit_count_q <= '0;
      zero_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      bit_count_q <= bit_count_d;
      zero_seen_q <= zero_seen_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign idx_valid = (state_q == DRAIN);
  assign idx       = low_idx;
  assign idx_last  = (state_q == DRAIN) && single_bit;
  assign zero_seen = zero_seen_q;
  assign bit_count = bit_count_q;

endmodule

// File: tb/tb_onehot_serial_encoder.sv
// Self-checking bench for onehot_serial_encoder: directed table, hand-written
// backpressure/flush/reset sequences, and random vectors against a queue model.
module tb_onehot_serial_encoder;
  localparam int N = 8;
  localparam int W = $clog2(N);

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [N-1:0] req_vec = '0;
  logic         flush = 1'b0;
  logic         idx_valid;
  logic         idx_ready = 1'b1;
  logic [W-1:0] idx;
  logic         idx_last;
  logic         zero_seen;
  logic [W:0]   bit_count;

  int checks = 0;
  int errors = 0;

  onehot_serial_encoder #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_vec(req_vec), .flush(flush), .idx_valid(idx_valid), .idx_ready(idx_ready),
    .idx(idx), .idx_last(idx_last), .zero_seen(zero_seen), .bit_count(bit_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [N-1:0] vec;
    int           beats;
    int           first_idx;
    int           last_idx;
  } vec_rec_t;

  // Drive one vector from IDLE and follow it to completion. rnd_ready selects
  // random backpressure; otherwise idx_ready stays high and timing is checked.
  task automatic run_vector(input logic [N-1:0] vec, input bit rnd_ready,
                            output int first_seen, output int last_seen);
    int q[$];
    int cycles;
    int k;
    first_seen = -1;
    last_seen  = -1;
    for (int b = 0; b < N; b++) if (vec[b]) q.push_back(b);
    k = q.size();
    chk("req_ready_before", int'(req_ready), 1);
    req_valid = 1'b1;
    req_vec   = vec;
    idx_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    req_vec   = '0;
    chk("bit_count", int'(bit_count), k);
    if (k == 0) begin
      chk("zero_seen_pulse", int'(zero_seen), 1);
      chk("zero_idx_valid", int'(idx_valid), 0);
      chk("zero_req_ready", int'(req_ready), 1);
      @(negedge clk);
      chk("zero_seen_clear", int'(zero_seen), 0);
      chk("zero_idx_valid2", int'(idx_valid), 0);
      return;
    end
    chk("zero_seen_quiet", int'(zero_seen), 0);
    cycles = 0;
    while (q.size() > 0 && cycles < 200) begin
      chk("idx_valid", int'(idx_valid), 1);
      chk("req_ready_drain", int'(req_ready), 0);
      chk("idx", int'(idx), q[0]);
      chk("idx_last", int'(idx_last), (q.size() == 1) ? 1 : 0);
      idx_ready = rnd_ready ? ($urandom_range(0, 9) < 7) : 1'b1;
      if (idx_ready) begin
        if (first_seen < 0) first_seen = int'(idx);
        last_seen = int'(idx);
        void'(q.pop_front());
      end
      @(negedge clk);
      cycles++;
    end
    chk("drain_timeout", q.size(), 0);
    if (!rnd_ready) chk("drain_cycles", cycles, k);
    idx_ready = 1'b1;
    chk("idle_idx_valid", int'(idx_valid), 0);
    chk("idle_req_ready", int'(req_ready), 1);
  endtask

  initial begin
    vec_rec_t tbl[5];
    int fs, ls;
    logic [N-1:0] v;

    tbl[0] = '{vec: 8'b0010_0101, beats: 3, first_idx: 0, last_idx: 5};
    tbl[1] = '{vec: 8'b1000_0000, beats: 1, first_idx: 7, last_idx: 7};
    tbl[2] = '{vec: 8'hFF,        beats: 8, first_idx: 0, last_idx: 7};
    tbl[3] = '{vec: 8'b0000_0001, beats: 1, first_idx: 0, last_idx: 0};
    tbl[4] = '{vec: 8'h00,        beats: 0, first_idx: -1, last_idx: -1};

    #2;
    chk("rst_req_ready", int'(req_ready), 1);
    chk("rst_idx_valid", int'(idx_valid), 0);
    chk("rst_idx", int'(idx), 0);
    chk("rst_idx_last", int'(idx_last), 0);
    chk("rst_bit_count", int'(bit_count), 0);
    chk("rst_zero_seen", int'(zero_seen), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 5; t++) begin
      run_vector(tbl[t].vec, 1'b0, fs, ls);
      chk("tbl_first_idx", fs, tbl[t].first_idx);
      chk("tbl_last_idx", ls, tbl[t].last_idx);
      chk("tbl_bit_count_held", int'(bit_count), tbl[t].beats);
    end

    // Backpressure: idx must hold at 3 while the consumer stalls.
    req_valid = 1'b1; req_vec = 8'b0001_1000;
    @(negedge clk);
    req_valid = 1'b0; req_vec = '0; idx_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("hold_idx", int'(idx), 3);
      chk("hold_valid", int'(idx_valid), 1);
      chk("hold_last", int'(idx_last), 0);
      @(negedge clk);
    end
    idx_ready = 1'b1;
    chk("rel_idx0", int'(idx), 3);
    @(negedge clk);
    chk("rel_idx1", int'(idx), 4);
    chk("rel_last1", int'(idx_last), 1);
    @(negedge clk);
    chk("rel_done", int'(idx_valid), 0);

    // Flush mid-drain discards the beat presented alongside it.
    req_valid = 1'b1; req_vec = 8'b1111_0000;
    @(negedge clk);
    req_valid = 1'b0; req_vec = '0;
    chk("fl_idx0", int'(idx), 4);
    @(negedge clk);
    chk("fl_idx1", int'(idx), 5);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fl_valid", int'(idx_valid), 0);
    chk("fl_ready", int'(req_ready), 1);
    chk("fl_bit_count", int'(bit_count), 4);
    run_vector(8'b0000_0011, 1'b0, fs, ls);
    chk("post_flush_last", ls, 1);

    // Flush in IDLE blocks a concurrent request.
    req_valid = 1'b1; req_vec = 8'h0F; flush = 1'b1;
    chk("idle_flush_ready", int'(req_ready), 1);
    @(negedge clk);
    req_valid = 1'b0; req_vec = '0; flush = 1'b0;
    chk("idle_flush_valid", int'(idx_valid), 0);
    chk("idle_flush_count", int'(bit_count), 2);
    @(negedge clk);
    chk("idle_flush_valid2", int'(idx_valid), 0);

    // Asynchronous reset mid-drain clears outputs without a clock edge.
    req_valid = 1'b1; req_vec = 8'b1111_0000;
    @(negedge clk);
    req_valid = 1'b0; req_vec = '0; idx_ready = 1'b0;
    chk("ar_pre_valid", int'(idx_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", int'(idx_valid), 0);
    chk("ar_ready", int'(req_ready), 1);
    chk("ar_idx", int'(idx), 0);
    chk("ar_last", int'(idx_last), 0);
    chk("ar_count", int'(bit_count), 0);
    @(negedge clk);
    rst_n = 1'b1; idx_ready = 1'b1;
    @(negedge clk);
    chk("ar_after_valid", int'(idx_valid), 0);
    run_vector(8'b0100_0010, 1'b0, fs, ls);
    chk("ar_after_first", fs, 1);

    // Random vectors with random backpressure against the queue model.
    for (int r = 0; r < 40; r++) begin
      v = N'($urandom);
      if (r % 8 == 0) v = '0;
      run_vector(v, 1'b1, fs, ls);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t expected finish earlier", $time);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/onehot_serial_encoder.md
Name: onehot_serial_encoder

Overview:
- Sequential encoder, the inverse of the team's binary-to-one-hot decoders.
- Accepts a multi-hot request vector through a valid/ready handshake.
- Emits the binary index of every set bit as a stream, lowest index first, one index per accepted output beat.
- Used wherever one-hot or multi-hot select lines must be turned back into binary addresses, e.g. interrupt or request collection feeding a binary-addressed consumer.

Parameters:
- N, 8, width of the request vector; legal range 2..32.
- W, $clog2(N), width of the emitted index; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request vector present.
- req_ready  output  1  block can accept a vector.
- req_vec  input  N  multi-hot request vector.
- flush  input  1  synchronous abort of the current vector.
- idx_valid  output  1  idx is valid.
- idx_ready  input  1  consumer accepts idx.
- idx  output  W  binary index of the lowest pending set bit.
- idx_last  output  1  this beat is the final index for the vector.
- zero_seen  output  1  one-cycle pulse: an all-zero vector was accepted.
- bit_count  output  W+1  popcount of the vector at load; held until the next load.

Behaviour:
- Reset is asynchronous on rst_n low. All registered state clears immediately:
  - state=IDLE, pending=0, bit_count=0, zero_seen=0.
  - Outputs: req_ready=1, idx_valid=0, idx=0, idx_last=0.
- States: IDLE and DRAIN. Register pending[N-1:0] holds the bits not yet emitted.
- IDLE:
  - req_ready=1, idx_valid=0.
  - On req_valid&&req_ready:
    - If req_vec!=0: pending<=req_vec, bit_count<=popcount(req_vec), state<=DRAIN.
    - If req_vec==0: stay IDLE, bit_count<=0, zero_seen pulses high for exactly the next cycle, no idx beat.
- DRAIN:
  - req_ready=0, idx_valid=1.
  - idx = position of the lowest set bit in pending. Combinational from registered pending, so it is stable for the whole cycle.
  - idx_last=1 iff pending has exactly one bit set.
  - On idx_ready, the lowest set bit of pending clears.
  - If that beat had idx_last=1, state<=IDLE. req_ready rises the following cycle; no same-cycle reload.
- Latency:
  - First idx_valid appears in the cycle after acceptance.
  - With idx_ready held high, a vector with k set bits produces k consecutive beats and returns to IDLE in k+1 cycles total from acceptance.
- Backpressure: while idx_valid&&!idx_ready, idx, idx_last and pending hold unchanged.
- flush:
  - In DRAIN: pending<=0, state<=IDLE on the next edge. Any beat in the same cycle is discarded even if idx_ready=1.
  - In IDLE: flush has priority over a concurrent request, so the vector is not accepted; req_ready still reads 1 that cycle.
- Boundaries:
  - Bit N-1 alone gives idx=N-1, idx_last=1.
  - All-ones gives N beats, idx 0..N-1 in order, idx_last only on N-1.
  - bit_count reaches N, which needs W+1 bits.
- Asynchronous reset mid-DRAIN abandons remaining beats with no partial output.
- Outputs are driven from registers plus the combinational lowest-set-bit logic on pending only. There is no combinational path from req_vec or idx_ready to idx or idx_valid.

Test Plan:
- Reset, then req_vec=8'b0010_0101 with idx_ready=1:
  - beats idx=0,2,5;
  - idx_last only on 5;
  - bit_count=3;
  - req_ready high again 4 cycles after acceptance.
- req_vec=8'b1000_0000 -> single beat idx=7, idx_last=1.
- req_vec=8'hFF -> 8 beats idx=0..7, bit_count=8.
- req_vec=0 -> zero_seen one-cycle pulse, idx_valid stays 0, req_ready stays 1.
- req_vec=8'b0001_1000 with idx_ready low 3 cycles -> idx=3 held stable across those cycles; release gives 3 then 4.
- Flush and reset mid-drain:
  - Vector 8'b1111_0000: after the first beat assert flush -> idx_valid=0 the next cycle, next vector accepted cleanly.
  - Repeat with rst_n pulsed low mid-drain -> outputs clear immediately without a clock edge.
